bp_fe_queue_fifo: RTL

//  Decoupling FIFO between the FE output (bp_fe_queue packets from pc_gen/itlb) and the BE.

---
 rtl/bp_fe_queue_fifo.sv | 77 +++++++
 1 files changed

// File: rtl/bp_fe_queue_fifo.sv
// Decoupling FIFO between the FE packet stream and the BE: circular buffer with
// wrap-bit pointers, registered occupancy and a single-cycle flush for wrong-path packets.
module bp_fe_queue_fifo #(
    parameter int entry_width_p = 32,
    parameter int els_p         = 8,
    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int cnt_width_lp = (els_p > 0) ? $clog2(els_p + 1) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [entry_width_p-1:0] fe_queue_i,
    input  logic                     fe_queue_v_i,
    output logic                     fe_queue_ready_o,
    output logic [entry_width_p-1:0] fe_queue_o,
    output logic                     fe_queue_v_o,
    input  logic                     fe_queue_yumi_i,
    input  logic                     flush_i,
    output logic [cnt_width_lp-1:0]  count_o
);

    localparam logic [ptr_width_lp:0]   ptr_one_lp = 1;
    localparam logic [cnt_width_lp-1:0] cnt_one_lp = 1;

    logic [ptr_width_lp:0]    rd_ptr, wr_ptr;
    logic [cnt_width_lp-1:0]  count_r;
    logic [entry_width_p-1:0] mem [els_p];

    logic [ptr_width_lp-1:0] rd_idx, wr_idx;
    logic empty, full, enq, deq;

    assign rd_idx = rd_ptr[ptr_width_lp-1:0];
    assign wr_idx = wr_ptr[ptr_width_lp-1:0];

    // Wrap bit distinguishes full from empty when the indices coincide.
    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_idx == wr_idx) && (rd_ptr[ptr_width_lp] != wr_ptr[ptr_width_lp]);

    assign fe_queue_ready_o = ~full;
    assign fe_queue_v_o     = ~empty;
    assign fe_queue_o       = mem[rd_idx];
    assign count_o          = count_r;

    assign enq = fe_queue_v_i & fe_queue_ready_o & ~flush_i;
    assign deq = fe_queue_yumi_i & ~flush_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_r <= '0;
        end else if (flush_i) begin
            rd_ptr  <= wr_ptr;
            count_r <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + ptr_one_lp;
            if (deq) rd_ptr <= rd_ptr + ptr_one_lp;
            case ({enq, deq})
                2'b10:   count_r <= count_r + cnt_one_lp;
                2'b01:   count_r <= count_r - cnt_one_lp;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage holds no reset; contents are only meaningful behind valid pointers.
    always_ff @(posedge clk_i) begin
        if (enq) mem[wr_idx] <= fe_queue_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(fe_queue_yumi_i && !fe_queue_v_o));
            assert (count_r == cnt_width_lp'(wr_ptr - rd_ptr));
        end
    end

endmodule
